// File: rtl/trb_in_demux.sv
// trb_in_demux: deals fixed-length byte frames round-robin into per-lane show-ahead FIFOs.
// Latency: a beat accepted at cycle t is visible on its lane output at cycle t+1.
// Backpressure: a frame starts only when the current lane can hold a whole frame; lanes drain on st_ready_in.
module trb_in_demux #(
  parameter int NUM_TURBO  = 2,
  parameter int FRAME_LEN  = 1024,
  parameter int FIFO_DEPTH = 2048
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             st_data_in,
  input  logic                   st_valid_in,
  input  logic                   st_sop_in,
  input  logic                   st_eop_in,
  output logic                   st_ready_out,
  output logic [8*NUM_TURBO-1:0] st_data_out,
  output logic [NUM_TURBO-1:0]   st_valid_out,
  output logic [NUM_TURBO-1:0]   st_sop_out,
  output logic [NUM_TURBO-1:0]   st_eop_out,
  input  logic [NUM_TURBO-1:0]   st_ready_in,
  output logic [3:0]             lane_sel,
  output logic                   err_sop,
  output logic                   err_len
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_LEN - 1);
  // Highest occupancy that still leaves room for one complete frame.
  localparam logic [AW:0]   START_MAX = (AW+1)'(FIFO_DEPTH - FRAME_LEN);

  typedef enum logic {S_IDLE, S_XFER} state_t;

  state_t        r_state, w_nxt_state;
  logic [CW-1:0] r_wr_cnt, w_nxt_wr_cnt;
  logic [3:0]    r_lane_sel, w_nxt_lane_sel;
  logic          r_err_sop, r_err_len;
  logic          w_ready, w_accept;
  logic [AW:0]   w_used [NUM_TURBO];
  logic [AW:0]   w_sel_used;

  // Occupancy of the lane that is owed the current/next frame.
  always_comb begin
    w_sel_used = '0;
    for (int i = 0; i < NUM_TURBO; i++) begin
      if (r_lane_sel == 4'(i)) w_sel_used = w_used[i];
    end
  end

  // Write FSM: room is checked only at frame start; mid-frame the input is never stalled.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_wr_cnt   = r_wr_cnt;
    w_nxt_lane_sel = r_lane_sel;
    w_ready        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = rst_n && (w_sel_used <= START_MAX);
        if (st_valid_in && w_ready) begin
          w_nxt_wr_cnt = CW'(1);
          w_nxt_state  = S_XFER;
        end
      end
      S_XFER: begin
        w_ready = rst_n;
        if (st_valid_in && w_ready) begin
          if (r_wr_cnt == LAST_BEAT) begin
            w_nxt_wr_cnt   = '0;
            w_nxt_lane_sel = (r_lane_sel == 4'(NUM_TURBO - 1)) ? 4'd0 : r_lane_sel + 4'd1;
            w_nxt_state    = S_IDLE;
          end else begin
            w_nxt_wr_cnt = r_wr_cnt + 1'b1;
          end
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  assign w_accept     = st_valid_in && w_ready;
  assign st_ready_out = w_ready;

  // Write-side state plus one-cycle framing error flags (framing itself follows wr_cnt only).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wr_cnt   <= '0;
      r_lane_sel <= '0;
      r_err_sop  <= 1'b0;
      r_err_len  <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_wr_cnt   <= w_nxt_wr_cnt;
      r_lane_sel <= w_nxt_lane_sel;
      r_err_sop  <= w_accept && (r_state == S_IDLE) && !st_sop_in;
      r_err_len  <= w_accept && (st_eop_in != (r_wr_cnt == LAST_BEAT));
    end
  end

  assign lane_sel = r_lane_sel;
  assign err_sop  = r_err_sop;
  assign err_len  = r_err_len;

  for (genvar g = 0; g < NUM_TURBO; g++) begin : g_lane
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_used;
    logic [CW-1:0] r_rd_cnt;
    logic          w_wr, w_rd, w_vld;

    assign w_vld     = (r_used != '0);
    assign w_wr      = w_accept && (r_lane_sel == 4'(g));
    assign w_rd      = w_vld && st_ready_in[g];
    assign w_used[g] = r_used;

    // Lane storage; contents need no reset because valid is derived from occupancy.
    always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= st_data_in;
    end

    // Pointers, occupancy and output beat position; read and write in one cycle both proceed.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_used   <= '0;
        r_rd_cnt <= '0;
      end else begin
        if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_rd) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
          r_rd_cnt <= (r_rd_cnt == LAST_BEAT) ? '0 : r_rd_cnt + 1'b1;
        end
        if (w_wr && !w_rd)      r_used <= r_used + 1'b1;
        else if (w_rd && !w_wr) r_used <= r_used - 1'b1;
      end
    end

    assign st_valid_out[g]     = w_vld;
    assign st_data_out[8*g +: 8] = w_vld ? r_mem[r_rd_ptr] : 8'h00;
    assign st_sop_out[g]       = w_vld && (r_rd_cnt == '0);
    assign st_eop_out[g]       = w_vld && (r_rd_cnt == LAST_BEAT);
  end

endmodule

// File: tb/tb_trb_in_demux.sv
// tb_trb_in_demux: randomized bench for trb_in_demux with a frame-level reference model and lane scoreboard.
// Latency: expects each accepted beat on its lane one cycle later, in round-robin frame order.
// Backpressure: lane ready is forced, blocked or randomized; input readiness is predicted from lane occupancy.
module tb_trb_in_demux;

  localparam int NT = 3;
  localparam int FL = 16;
  localparam int FD = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [7:0]      st_data_in;
  logic            st_valid_in;
  logic            st_sop_in;
  logic            st_eop_in;
  logic            st_ready_out;
  logic [8*NT-1:0] st_data_out;
  logic [NT-1:0]   st_valid_out;
  logic [NT-1:0]   st_sop_out;
  logic [NT-1:0]   st_eop_out;
  logic [NT-1:0]   st_ready_in;
  logic [3:0]      lane_sel;
  logic            err_sop;
  logic            err_len;

  trb_in_demux #(.NUM_TURBO(NT), .FRAME_LEN(FL), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_data_in(st_data_in), .st_valid_in(st_valid_in),
    .st_sop_in(st_sop_in), .st_eop_in(st_eop_in),
    .st_ready_out(st_ready_out),
    .st_data_out(st_data_out), .st_valid_out(st_valid_out),
    .st_sop_out(st_sop_out), .st_eop_out(st_eop_out),
    .st_ready_in(st_ready_in),
    .lane_sel(lane_sel), .err_sop(err_sop), .err_len(err_len)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       s;
    logic       e;
  } beat_t;

  beat_t         lane_q [NT][$];
  int            checks = 0;
  int            errors = 0;
  int            acc_beats = 0;
  int            stall_cycles = 0;
  logic          exp_err_sop = 1'b0;
  logic          exp_err_len = 1'b0;
  logic          rdy_rand = 1'b0;
  logic [NT-1:0] rdy_block = '0;

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model + scoreboard: frame n of the stream belongs to lane n mod NT,
  // a frame may start only when that lane has FL free entries.
  int    m_lane, m_pos;
  bit    m_acc, m_rdy;
  beat_t m_b, m_head;
  initial forever begin
    @(negedge clk);
    m_lane = (acc_beats / FL) % NT;
    m_pos  = acc_beats % FL;
    if (!rst_n) begin
      chk("ready_in_reset", 32'(st_ready_out), 32'd0);
      for (int i = 0; i < NT; i++) lane_q[i].delete();
      acc_beats   = 0;
      exp_err_sop = 1'b0;
      exp_err_len = 1'b0;
    end else begin
      m_rdy = (m_pos != 0) || ((FD - lane_q[m_lane].size()) >= FL);
      chk("ready", 32'(st_ready_out), 32'(m_rdy));
      chk("lane_sel", 32'(lane_sel), 32'(m_lane));
      chk("err_sop", 32'(err_sop), 32'(exp_err_sop));
      chk("err_len", 32'(err_len), 32'(exp_err_len));
      for (int i = 0; i < NT; i++) begin
        chk($sformatf("valid[%0d]", i), 32'(st_valid_out[i]), 32'(lane_q[i].size() != 0));
        if (st_valid_out[i] && lane_q[i].size() != 0) begin
          m_head = lane_q[i][0];
          chk($sformatf("data[%0d]", i), 32'(st_data_out[8*i +: 8]), 32'(m_head.d));
          chk($sformatf("sop[%0d]", i), 32'(st_sop_out[i]), 32'(m_head.s));
          chk($sformatf("eop[%0d]", i), 32'(st_eop_out[i]), 32'(m_head.e));
          if (st_ready_in[i]) void'(lane_q[i].pop_front());
        end
      end
      m_acc = st_valid_in && st_ready_out;
      if (st_valid_in && !st_ready_out) stall_cycles++;
      exp_err_sop = m_acc && (m_pos == 0) && !st_sop_in;
      exp_err_len = m_acc && (st_eop_in != (m_pos == FL - 1));
      if (m_acc) begin
        m_b.d = st_data_in;
        m_b.s = (m_pos == 0);
        m_b.e = (m_pos == FL - 1);
        lane_q[m_lane].push_back(m_b);
        acc_beats++;
      end
    end
  end

  // Lane-side readiness: all ready, randomized, with optional per-lane hard block.
  initial begin
    st_ready_in = '1;
    forever begin
      @(posedge clk);
      #1;
      st_ready_in = (rdy_rand ? NT'($urandom) : {NT{1'b1}}) & ~rdy_block;
    end
  end

  // Drives one beat (after optional random idle gap) and holds it until accepted.
  task automatic send_beat(input logic [7:0] d, input logic s, input logic e, input int gap_pct);
    int waited;
    bit done;
    while (int'($urandom_range(99)) < gap_pct) begin
      st_valid_in = 1'b0;
      @(posedge clk);
      #1;
    end
    st_valid_in = 1'b1;
    st_data_in  = d;
    st_sop_in   = s;
    st_eop_in   = e;
    waited = 0;
    done   = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (st_ready_out) begin
        done = 1'b1;
      end else if (waited == 2000) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: st_ready_out low for %0d cycles, required 1", waited);
        done = 1'b1;
      end else begin
        waited++;
      end
    end
    @(posedge clk);
    #1;
    st_valid_in = 1'b0;
  endtask

  task automatic send_frame(input int fidx, input int eop_pos, input logic sop_bit,
                            input int gap_pct, input bit rnd_data, input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      send_beat(rnd_data ? 8'($urandom) : 8'(fidx), (k == 0) ? sop_bit : 1'b0,
                k == eop_pos, gap_pct);
    end
  endtask

  // Waits (bounded) for every lane to empty in the model, then confirms nothing is left.
  task automatic drain();
    int n;
    n = 0;
    while ((lane_q[0].size() + lane_q[1].size() + lane_q[2].size()) != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    for (int i = 0; i < NT; i++) chk($sformatf("drained[%0d]", i), 32'(lane_q[i].size()), 32'd0);
  endtask

  int s0;
  initial begin
    rst_n       = 1'b0;
    st_valid_in = 1'b0;
    st_data_in  = '0;
    st_sop_in   = 1'b0;
    st_eop_in   = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back frames, all lanes ready: full rate, no stalls, no errors.
    for (int f = 0; f < 4; f++) send_frame(f, FL - 1, 1'b1, 0, 1'b0, FL);
    drain();

    // Lane 1 blocked: the frame owed to lane 1 must stall although other lanes have room.
    rdy_block = 3'b010;
    s0 = stall_cycles;
    fork
      for (int f = 0; f < 8; f++) send_frame(16 + f, FL - 1, 1'b1, 0, 1'b0, FL);
      begin
        repeat (300) @(posedge clk);
        #1;
        rdy_block = '0;
      end
    join
    chk("lane_stall_seen", 32'((stall_cycles - s0) > 0), 32'd1);
    drain();

    // Early eop, then a clean frame: framing stays at FL beats.
    send_frame(40, 10, 1'b1, 0, 1'b1, FL);
    send_frame(41, FL - 1, 1'b1, 0, 1'b1, FL);
    // Missing sop on first beat, then a clean frame.
    send_frame(42, FL - 1, 1'b0, 0, 1'b1, FL);
    send_frame(43, FL - 1, 1'b1, 0, 1'b1, FL);
    drain();

    // Random input gaps and random lane readiness.
    rdy_rand = 1'b1;
    for (int f = 0; f < 64; f++) send_frame(f, FL - 1, 1'b1, 30, 1'b1, FL);
    rdy_rand = 1'b0;
    drain();

    // One-cycle reset in the middle of the third frame; next frame restarts on lane 0.
    send_frame(60, FL - 1, 1'b1, 0, 1'b1, FL);
    send_frame(61, FL - 1, 1'b1, 0, 1'b1, FL);
    send_frame(62, FL - 1, 1'b1, 0, 1'b1, 7);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(63, FL - 1, 1'b1, 0, 1'b1, FL);
    drain();

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
